// File: rtl/muldiv_seq_if.sv
// Pipeline <-> multiply/divide sequencer bundle.
// master = pipeline side, slave = muldiv_seq.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       func;
    logic [WIDTH-1:0] op_0;
    logic [WIDTH-1:0] op_1;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, func, op_0, op_1, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, func, op_0, op_1, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN: zero-operand mult / zero-divisor div finish in one cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] op0_raw;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_p;
    logic             neg_r;
    logic             dz;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             signed_op;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] mag0;
    logic [WIDTH-1:0] mag1;
    logic             accept;
    logic             last;
    logic             early;
    logic [WIDTH-1:0] early_hi;
    logic [WIDTH-1:0] early_lo;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   a_nx;
    logic [WIDTH-1:0]   q_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Launch decode: operand magnitudes, signs and early-out detection
    always_comb begin
        signed_op = ~bus.func[0];
        s0        = signed_op & bus.op_0[WIDTH-1];
        s1        = signed_op & bus.op_1[WIDTH-1];
        mag0      = s0 ? (~bus.op_0 + 1'b1) : bus.op_0;
        mag1      = s1 ? (~bus.op_1 + 1'b1) : bus.op_1;
        accept    = (state == IDLE) && bus.start;
        last      = (state == RUN) && (cnt == CW'(WIDTH - 1));
        early     = 1'b0;
        early_hi  = '0;
        early_lo  = '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (bus.func[1]) begin
            early    = (bus.op_1 == '0);
            early_hi = bus.op_0;
            early_lo = '1;
        end else begin
            early    = (bus.op_0 == '0) || (bus.op_1 == '0);
        end
`endif
    end

    // FSM next-state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = early ? DONE : RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_r <= (state_nx != IDLE);
            done_r <= (state_nx == DONE);
        end
    end

    // One shift-add or restoring-divide step, plus sign fix-up of the final value
    always_comb begin
        mul_sum = {1'b0, a} + (q[0] ? {1'b0, b} : '0);
        shifted = {a, q[WIDTH-1]};
        trial   = shifted - {1'b0, b};
        if (is_div) begin
            if (trial[WIDTH]) begin
                a_nx = shifted[WIDTH-1:0];
                q_nx = {q[WIDTH-2:0], 1'b0};
            end else begin
                a_nx = trial[WIDTH-1:0];
                q_nx = {q[WIDTH-2:0], 1'b1};
            end
        end else begin
            a_nx = mul_sum[WIDTH:1];
            q_nx = {mul_sum[0], q[WIDTH-1:1]};
        end
        prod = {a_nx, q_nx};
        if (neg_p) prod = ~prod + 1'b1;
        quo = neg_p ? (~q_nx + 1'b1) : q_nx;
        rem = neg_r ? (~a_nx + 1'b1) : a_nx;
        if (!is_div) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            res_hi = op0_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes
    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            b       <= '0;
            op0_raw <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            if (state == IDLE) begin
                if (bus.hi_we) hi_r <= bus.wdata;
                if (bus.lo_we) lo_r <= bus.wdata;
            end
            if (accept) begin
                a       <= '0;
                q       <= bus.func[1] ? mag0 : mag1;
                b       <= bus.func[1] ? mag1 : mag0;
                op0_raw <= bus.op_0;
                cnt     <= '0;
                is_div  <= bus.func[1];
                neg_p   <= s0 ^ s1;
                neg_r   <= s0;
                dz      <= bus.func[1] && (bus.op_1 == '0);
                if (early) begin
                    hi_r <= early_hi;
                    lo_r <= early_lo;
                end
            end else if (state == RUN) begin
                a   <= a_nx;
                q   <= q_nx;
                cnt <= cnt + CW'(1);
                if (last) begin
                    hi_r <= res_hi;
                    lo_r <= res_lo;
                end
            end
        end
    end
endmodule
